// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and memory-side bus shared by mem_arbiter.
// slave: the arbiter; master: the core plus memory that surround it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_valid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_width;
    logic              d_ext;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_misalign;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_width, d_ext, d_addr, d_wdata, mem_rdata,
        output i_valid, i_rdata, d_valid, d_rdata, d_misalign,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_width, d_ext, d_addr, d_wdata, mem_rdata,
        input  i_valid, i_rdata, d_valid, d_rdata, d_misalign,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins a tie.
module mem_arbiter #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       win_d, win_we, win_ext;
    logic [1:0] win_width, win_off;
    logic       grant_any, grant_d, misalign;
    logic       unused_bits;
`ifdef ARB_RR_EN
    logic       ptr_d;
`endif

    assign unused_bits = ^bus.i_addr[1:0];

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [31:0] data, input logic [1:0] width);
        case (width)
            2'b00:   lane_rep = {4{data[7:0]}};
            2'b01:   lane_rep = {2{data[15:0]}};
            default: lane_rep = data;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] width,
                                             input logic [1:0] off, input logic zext);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (width)
            2'b00:   load_ext = zext ? 32'(sh[7:0])  : 32'(b);
            2'b01:   load_ext = zext ? 32'(sh[15:0]) : 32'(h);
            default: load_ext = word;
        endcase
    endfunction

    always_comb begin
        grant_any = bus.i_req | bus.d_req;
`ifdef ARB_RR_EN
        grant_d   = bus.d_req & (~bus.i_req | ptr_d);
`else
        grant_d   = bus.d_req;
`endif
        misalign   = grant_d & is_misaligned(bus.d_width, bus.d_addr[1:0]);
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = misalign ? ERR : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Winner payload: sampled once at grant, never again for this access
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_any) begin
            win_d     <= grant_d;
            win_we    <= grant_d & bus.d_we;
            win_ext   <= bus.d_ext;
            win_width <= bus.d_width;
            win_off   <= bus.d_addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            bus.i_valid    <= 1'b0;
            bus.i_rdata    <= '0;
            bus.d_valid    <= 1'b0;
            bus.d_rdata    <= '0;
            bus.d_misalign <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
`ifdef ARB_RR_EN
            ptr_d          <= 1'b1;
`endif
        end else begin
            bus.i_valid    <= 1'b0;
            bus.d_valid    <= 1'b0;
            bus.d_misalign <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
`ifdef ARB_RR_EN
                        ptr_d <= ~grant_d;
`endif
                        if (misalign) begin
                            bus.d_valid    <= 1'b1;
                            bus.d_misalign <= 1'b1;
                            bus.d_rdata    <= '0;
                        end else begin
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= grant_d & bus.d_we;
                            bus.mem_be    <= grant_d ? byte_en(bus.d_width, bus.d_addr[1:0]) : 4'b1111;
                            bus.mem_addr  <= grant_d ? {bus.d_addr[ADDR_W-1:2], 2'b00}
                                                     : {bus.i_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_wdata <= (grant_d & bus.d_we) ? lane_rep(bus.d_wdata, bus.d_width) : '0;
                            cnt           <= 4'(LATENCY);
                        end
                    end
                end
                ACCESS: begin
                    // Counter hits zero in the cycle mem_rdata is valid
                    if (cnt == 4'd0) begin
                        if (win_d) begin
                            bus.d_valid <= 1'b1;
                            bus.d_rdata <= win_we ? '0 : load_ext(bus.mem_rdata, win_width, win_off, win_ext);
                        end else begin
                            bus.i_valid <= 1'b1;
                            bus.i_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=1 instance for function and arbitration,
// a LATENCY=4 instance for reset during an access.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst4;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [31:0] mem_word = '0;
    logic [3:0]  rd_cnt = '0;
    logic [3:0]  rd_cnt4 = '0;

    int          r_en_cyc, r_en_cnt, r_v_cyc, r_extra;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_we, r_mis;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus4 ();

    mem_arbiter #(.LATENCY(1), .ADDR_W(ADDR_W)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.LATENCY(4), .ADDR_W(ADDR_W)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    always #5 clk = ~clk;

    // Fixed-latency memories: data is only valid in the cycle LATENCY after mem_en
    always @(posedge clk) begin
        if (bus.mem_en)        rd_cnt <= 4'd1;
        else if (rd_cnt != 0)  rd_cnt <= rd_cnt - 4'd1;
        if (bus4.mem_en)       rd_cnt4 <= 4'd4;
        else if (rd_cnt4 != 0) rd_cnt4 <= rd_cnt4 - 4'd1;
    end
    assign bus.mem_rdata  = (rd_cnt == 4'd1)  ? mem_word : 32'hDEADBEEF;
    assign bus4.mem_rdata = (rd_cnt4 == 4'd1) ? 32'h1234ABCD : 32'hDEADBEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_txn(input bit is_d, input logic [31:0] addr, input bit we,
                           input logic [1:0] width, input bit ext, input logic [31:0] wdata,
                           input logic [31:0] rword);
        bit got;
        mem_word = rword;
        r_en_cyc = -1; r_en_cnt = 0; r_v_cyc = -1; r_extra = 0;
        r_be = '0; r_addr = '0; r_wdata = '0; r_rdata = '0; r_we = 1'b0; r_mis = 1'b0;
        if (is_d) begin
            bus.d_we = we; bus.d_width = width; bus.d_ext = ext;
            bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        end else begin
            bus.i_addr = addr; bus.i_req = 1'b1;
        end
        for (int k = 1; k <= 30 && r_v_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                r_en_cnt++;
                if (r_en_cyc < 0) begin
                    r_en_cyc = k; r_be = bus.mem_be; r_addr = bus.mem_addr;
                    r_wdata = bus.mem_wdata; r_we = bus.mem_we;
                end
            end
            got = is_d ? bus.d_valid : bus.i_valid;
            if (got) begin
                r_v_cyc = k;
                r_rdata = is_d ? bus.d_rdata : bus.i_rdata;
                r_mis   = bus.d_misalign;
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_en || bus.i_valid || bus.d_valid) r_extra++;
        end
    endtask

    task automatic run_tie(input bit drop_d, input int n, output logic [3:0] seq, output int gap);
        int got_n;
        int last;
        seq = '0; got_n = 0; last = -1; gap = -1;
        mem_word = 32'h0;
        bus.i_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 1'b0;
        bus.d_width = 2'b10; bus.d_ext = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 1; k <= 60 && got_n < n; k++) begin
            @(negedge clk);
            if (bus.d_valid || bus.i_valid) begin
                seq = {seq[2:0], bus.d_valid};
                if (got_n == 1) gap = k - last;
                last = k;
                got_n++;
                if (drop_d && bus.d_valid) bus.d_req = 1'b0;
                if (got_n == n) begin
                    bus.i_req = 1'b0;
                    bus.d_req = 1'b0;
                end
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  seq;
        int          gap;
        int          seen;
        int          v;
        logic [31:0] rd;

        rst = 1'b0; rst4 = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_width = 2'b00; bus.d_ext = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus4.i_req = 1'b0; bus4.i_addr = '0; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
        bus4.d_width = 2'b00; bus4.d_ext = 1'b0; bus4.d_addr = '0; bus4.d_wdata = '0;

        repeat (2) @(negedge clk);
        check_eq("rst.mem_en",   32'(bus.mem_en), 0);
        check_eq("rst.mem_addr", bus.mem_addr, 0);
        check_eq("rst.mem_be",   32'(bus.mem_be), 0);
        check_eq("rst.i_valid",  32'(bus.i_valid), 0);
        check_eq("rst.d_valid",  32'(bus.d_valid), 0);
        check_eq("rst.d_mis",    32'(bus.d_misalign), 0);
        check_eq("rst.d_rdata",  bus.d_rdata, 0);
        rst = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        check_eq("idle.mem_en", 32'(bus.mem_en), 0);

        run_txn(1'b0, 32'h00400000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h00000013);
        check_eq("fetch.en_cyc", r_en_cyc, 1);
        check_eq("fetch.en_cnt", r_en_cnt, 1);
        check_eq("fetch.addr",   r_addr, 32'h00400000);
        check_eq("fetch.be",     32'(r_be), 32'hF);
        check_eq("fetch.we",     32'(r_we), 0);
        check_eq("fetch.v_cyc",  r_v_cyc, 3);
        check_eq("fetch.rdata",  r_rdata, 32'h00000013);
        check_eq("fetch.extra",  r_extra, 0);

        run_txn(1'b0, 32'h00400007, 1'b0, 2'b10, 1'b0, 32'h0, 32'h00000093);
        check_eq("fetch_lo.addr",  r_addr, 32'h00400004);
        check_eq("fetch_lo.rdata", r_rdata, 32'h00000093);

        run_txn(1'b1, 32'h1002, 1'b0, 2'b00, 1'b0, 32'h0, 32'h00800000);
        check_eq("lb.rdata", r_rdata, 32'hFFFFFF80);
        check_eq("lb.be",    32'(r_be), 32'h4);
        check_eq("lb.addr",  r_addr, 32'h1000);
        check_eq("lb.v_cyc", r_v_cyc, 3);
        check_eq("lb.mis",   32'(r_mis), 0);
        run_txn(1'b1, 32'h1002, 1'b0, 2'b00, 1'b1, 32'h0, 32'h00800000);
        check_eq("lbu.rdata", r_rdata, 32'h00000080);
        run_txn(1'b1, 32'h1001, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000A500);
        check_eq("lbu1.rdata", r_rdata, 32'h000000A5);
        check_eq("lbu1.be",    32'(r_be), 32'h2);
        run_txn(1'b1, 32'h1002, 1'b0, 2'b01, 1'b0, 32'h0, 32'h80010000);
        check_eq("lh2.rdata", r_rdata, 32'hFFFF8001);
        check_eq("lh2.be",    32'(r_be), 32'hC);
        run_txn(1'b1, 32'h1000, 1'b0, 2'b01, 1'b0, 32'h0, 32'h1234F00F);
        check_eq("lh0.rdata", r_rdata, 32'hFFFFF00F);
        run_txn(1'b1, 32'h1004, 1'b0, 2'b10, 1'b0, 32'h0, 32'h89ABCDEF);
        check_eq("lw.rdata", r_rdata, 32'h89ABCDEF);
        check_eq("lw.addr",  r_addr, 32'h1004);

        run_txn(1'b1, 32'h2002, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 32'h0);
        check_eq("sh.we",    32'(r_we), 1);
        check_eq("sh.be",    32'(r_be), 32'hC);
        check_eq("sh.wdata", r_wdata, 32'hBEEFBEEF);
        check_eq("sh.addr",  r_addr, 32'h2000);
        check_eq("sh.rdata", r_rdata, 0);
        check_eq("sh.v_cyc", r_v_cyc, 3);
        run_txn(1'b1, 32'h2001, 1'b1, 2'b00, 1'b0, 32'h123456AB, 32'h0);
        check_eq("sb.be",    32'(r_be), 32'h2);
        check_eq("sb.wdata", r_wdata, 32'hABABABAB);
        run_txn(1'b1, 32'h2004, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0);
        check_eq("sw.be",    32'(r_be), 32'hF);
        check_eq("sw.wdata", r_wdata, 32'hCAFEF00D);
        check_eq("sw.addr",  r_addr, 32'h2004);

        run_txn(1'b1, 32'h3001, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check_eq("mis_w.v_cyc",  r_v_cyc, 1);
        check_eq("mis_w.mis",    32'(r_mis), 1);
        check_eq("mis_w.en_cnt", r_en_cnt, 0);
        check_eq("mis_w.extra",  r_extra, 0);
        run_txn(1'b1, 32'h3003, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        check_eq("mis_h.v_cyc", r_v_cyc, 1);
        check_eq("mis_h.mis",   32'(r_mis), 1);
        run_txn(1'b1, 32'h3000, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check_eq("mis_rsv.mis",    32'(r_mis), 1);
        check_eq("mis_rsv.en_cnt", r_en_cnt, 0);
        run_txn(1'b1, 32'h3002, 1'b0, 2'b01, 1'b1, 32'h0, 32'h55660000);
        check_eq("ok_h.mis",   32'(r_mis), 0);
        check_eq("ok_h.v_cyc", r_v_cyc, 3);
        check_eq("ok_h.rdata", r_rdata, 32'h00005566);

        apply_reset();
        run_tie(1'b1, 2, seq, gap);
        check_eq("tie_drop.seq", 32'(seq), 32'h2);
        check_eq("tie_drop.gap", gap, 4);
        run_tie(1'b0, 4, seq, gap);
`ifdef ARB_RR_EN
        check_eq("tie_held.seq", 32'(seq), 32'hA);
`else
        check_eq("tie_held.seq", 32'(seq), 32'hF);
`endif
        check_eq("tie_held.gap", gap, 4);

        bus4.i_addr = 32'h40;
        bus4.i_req  = 1'b1;
        @(negedge clk);
        check_eq("rst4.en_cyc1", 32'(bus4.mem_en), 1);
        rst4 = 1'b0;
        bus4.i_req = 1'b0;
        #1;
        check_eq("rst4.mem_en",   32'(bus4.mem_en), 0);
        check_eq("rst4.mem_addr", bus4.mem_addr, 0);
        check_eq("rst4.i_valid",  32'(bus4.i_valid), 0);
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.i_valid || bus4.d_valid || bus4.mem_en) seen++;
        end
        check_eq("rst4.no_valid", seen, 0);
        bus4.i_addr = 32'h44;
        bus4.i_req  = 1'b1;
        v = -1; rd = '0;
        for (int k = 1; k <= 30 && v < 0; k++) begin
            @(negedge clk);
            if (bus4.i_valid) begin
                v  = k;
                rd = bus4.i_rdata;
                bus4.i_req = 1'b0;
            end
        end
        bus4.i_req = 1'b0;
        check_eq("rst4.refetch_cyc",  v, 6);
        check_eq("rst4.refetch_data", rd, 32'h1234ABCD);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
